// File: rtl/pipe_hazard_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_hazard_pkg                                                      |
// | Shared tag type and register/forwarding constants for the hazard     |
// | controller.                                                          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package pipe_hazard_pkg;

  // Widest register index a tag can carry; RB must not exceed it.
  localparam int RB_MAX    = 8;
  localparam int XZR_IDX   = 31;
  localparam int FWD_RF    = 0;
  localparam int FWD_EXMEM = 1;
  localparam int FWD_MEMWB = 2;

  typedef struct packed {
    logic              valid;
    logic [RB_MAX-1:0] rd;
    logic              regwrite;
    logic              memread;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

endpackage
`default_nettype wire

// File: rtl/hazard_tag_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_tag_pipe                                                      |
// | DEPTH-entry destination-tag shift register with bubble insert and    |
// | branch flush of the entries younger than BR_STG.                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module hazard_tag_pipe
  import pipe_hazard_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int BR_STG = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_flush,
  input  logic [TAG_W-1:0]       i_tag,
  output logic [DEPTH*TAG_W-1:0] o_tags
);

  tag_t w_in;
  tag_t r_tag [DEPTH];

  assign w_in = i_tag;

  // The branch itself keeps moving; everything younger than it is killed.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_tag[0] <= i_flush ? '0 : w_in;
      for (int i = 1; i < DEPTH; i++) begin
        r_tag[i] <= (i_flush && (i <= BR_STG)) ? '0 : r_tag[i-1];
      end
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign o_tags[i*TAG_W +: TAG_W] = r_tag[i];
  end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_hazard_ctrl                                                     |
// | Hazard/forwarding controller for the 5-stage pipeline: stall/bubble, |
// | taken-branch flush, registered EX forwarding selects, event counters.|
// | Build option: PIPE_FWD_EN (forwarding + load-use-only stalls).       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int RB     = 5,
  parameter int DEPTH  = 3,
  parameter int BR_STG = 1,
  parameter int RF_BYP = 0,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [RB-1:0]            id_ra1,
  input  logic [RB-1:0]            id_ra2,
  input  logic                     id_use1,
  input  logic                     id_use2,
  input  logic [RB-1:0]            id_rd,
  input  logic                     id_regwrite,
  input  logic                     id_memread,
  input  logic                     branch_taken,
  output logic                     pc_write,
  output logic                     if_id_write,
  output logic                     id_ex_bubble,
  output logic                     flush,
  output logic [$clog2(DEPTH)-1:0] fwd_a,
  output logic [$clog2(DEPTH)-1:0] fwd_b,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         flush_cnt
);

  localparam int                 FW        = $clog2(DEPTH);
  localparam int                 HLAST     = (RF_BYP != 0) ? DEPTH - 2 : DEPTH - 1;
  localparam logic [DEPTH-1:0]   c_HMASK   = DEPTH'((1 << (HLAST + 1)) - 1);
  localparam logic [FW-1:0]      c_FWD_RF  = FW'(FWD_RF);
  localparam logic [CNT_W-1:0]   c_CNT_MAX = '1;

  tag_t                   w_in_tag;
  logic [TAG_W-1:0]       w_in_flat;
  logic [DEPTH*TAG_W-1:0] w_tags_flat;
  tag_t                   w_tags [DEPTH];
  logic [DEPTH-1:0]       w_m1;
  logic [DEPTH-1:0]       w_m2;
  logic [DEPTH-1:0]       w_unused_tags;
  logic                   w_unused;
  logic                   w_use1;
  logic                   w_use2;
  logic [RB_MAX-1:0]      w_ra1_x;
  logic [RB_MAX-1:0]      w_ra2_x;
  logic                   w_raw_stall;
  logic                   w_stall;
  logic [CNT_W-1:0]       r_stall_cnt;
  logic [CNT_W-1:0]       r_flush_cnt;

  // XZR reads never depend on a producer.
  assign w_use1  = id_valid & id_use1 & (id_ra1 != RB'(XZR_IDX));
  assign w_use2  = id_valid & id_use2 & (id_ra2 != RB'(XZR_IDX));
  assign w_ra1_x = RB_MAX'(id_ra1);
  assign w_ra2_x = RB_MAX'(id_ra2);

  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    assign w_tags[i] = w_tags_flat[i*TAG_W +: TAG_W];
    assign w_m1[i]   = w_tags[i].valid & w_tags[i].regwrite &
                       (w_tags[i].rd == w_ra1_x) & w_use1;
    assign w_m2[i]   = w_tags[i].valid & w_tags[i].regwrite &
                       (w_tags[i].rd == w_ra2_x) & w_use2;
    assign w_unused_tags[i] = ^w_tags[i];
  end

  assign w_unused = ^{w_unused_tags, w_m1, w_m2};

`ifdef PIPE_FWD_EN
  assign w_raw_stall = (w_m1[0] | w_m2[0]) & w_tags[0].memread;
`else
  assign w_raw_stall = |((w_m1 | w_m2) & c_HMASK);
`endif

  // A taken branch wins: the stalled instruction is squashed anyway.
  assign w_stall      = w_raw_stall & ~branch_taken;
  assign flush        = branch_taken;
  assign pc_write     = ~w_stall;
  assign if_id_write  = ~w_stall & ~branch_taken;
  assign id_ex_bubble = w_stall | branch_taken;

  always_comb begin
    w_in_tag          = '0;
    w_in_tag.valid    = id_valid & ~w_stall;
    w_in_tag.rd       = RB_MAX'(id_rd);
    w_in_tag.regwrite = id_regwrite;
    w_in_tag.memread  = id_memread;
  end

  assign w_in_flat = w_in_tag;

  hazard_tag_pipe #(
    .DEPTH  (DEPTH),
    .BR_STG (BR_STG)
  ) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .i_flush (branch_taken),
    .i_tag   (w_in_flat),
    .o_tags  (w_tags_flat)
  );

`ifdef PIPE_FWD_EN
  logic [FW-1:0] r_fwd_a;
  logic [FW-1:0] r_fwd_b;

  // Scan oldest to youngest so the youngest producer overrides.
  function automatic logic [FW-1:0] pick_src(input logic [DEPTH-1:0] m);
    logic [FW-1:0] sel;
    sel = c_FWD_RF;
    for (int j = DEPTH - 2; j >= 0; j--) begin
      if (m[j]) sel = FW'(j + 1);
    end
    return sel;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fwd_a <= c_FWD_RF;
      r_fwd_b <= c_FWD_RF;
    end else if (w_raw_stall || branch_taken) begin
      r_fwd_a <= c_FWD_RF;
      r_fwd_b <= c_FWD_RF;
    end else begin
      r_fwd_a <= pick_src(w_m1);
      r_fwd_b <= pick_src(w_m2);
    end
  end

  assign fwd_a = r_fwd_a;
  assign fwd_b = r_fwd_b;
`else
  assign fwd_a = c_FWD_RF;
  assign fwd_b = c_FWD_RF;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != c_CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (branch_taken && (r_flush_cnt != c_CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire
